mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter and access sequencer for the 32 x 8 synchronous scratch memory (registered read and write ports). It accepts single-beat read/write requests from two requesters over valid/ready handshakes and drives the memory's `read`/`write`/`addr`/`data_in` strobes one access at a time. It returns read data with a one-cycle response pulse to the requester that issued the read, and it never presents `read` and `write` together.

## Interface

- `ADDR_W`, 5, address width; must equal the memory's address width.
- `DATA_W`, 8, data width; must equal the memory's data width.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `r0_valid`, `r1_valid`  in  1  request pending from requester 0 / 1.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  ADDR_W  request address.
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data; ignored for reads.
- `r0_ready`, `r1_ready`  out  1  request accepted this cycle.
- `r0_rsp_valid`, `r1_rsp_valid`  out  1  one-cycle pulse: `rsp_rdata` holds this requester's read data.
- `rsp_rdata`  out  DATA_W  read data, shared by both requesters.
- `mem_read`, `mem_write`  out  1  memory strobes (registered).
- `mem_addr`  out  ADDR_W  memory address (registered).
- `mem_wdata`  out  DATA_W  memory write data (registered).
- `mem_rdata`  in  DATA_W  memory `data_out`.
- `busy`  out  1  1 in any state other than IDLE.

## Operation

- FSM states: IDLE, ACCESS, RDWAIT.
- **IDLE**
  - `rX_ready` is combinational: it is high for the requester selected by arbitration, and only when that requester's valid is high.
  - A handshake is `rX_valid && rX_ready`. On a handshake, the request fields are loaded into the `mem_*` registers and the FSM goes to ACCESS.
  - `mem_read` is loaded with `!we` and `mem_write` is loaded with `we`.
- **Arbitration**
  - If only one requester is valid, it is selected.
  - If both are valid, the requester that was not granted last is selected.
  - `last_grant` updates only on a handshake.
  - After reset, `last_grant` = 1, so requester 0 wins the first tie.
- **ACCESS** (exactly one cycle)
  - The `mem_*` strobes are asserted.
  - For a write, the memory writes at the end of this cycle, and the FSM goes to IDLE with strobes cleared. Writes produce no response.
  - For a read, the memory registers `data_out` at the end of this cycle, and the FSM goes to RDWAIT with strobes cleared.
- **RDWAIT** (exactly one cycle)
  - `mem_rdata` is valid during this cycle.
  - At its end, `mem_rdata` is captured into `rsp_rdata`, the `rsp_valid` of the issuing requester (stored as `rsp_id`) is set for one cycle, and the FSM goes to IDLE.
  - A new handshake may occur in that same IDLE cycle.
- **Output rules**
  - `rsp_rdata` holds its value until the next read capture.
  - `rX_ready` is 0 in ACCESS and RDWAIT.
  - `mem_read && mem_write` is never 1.
- **Requester protocol**
  - Requesters hold valid, we, addr and wdata stable until ready.
  - A requester that drops valid before ready is simply not served; no error is raised.
- **Reset**
  - `rst` forces the FSM to IDLE immediately, independent of `clk`.
  - All outputs go to 0, including `rsp_rdata`, `mem_addr` and `mem_wdata`. `last_grant` goes to 1.
  - An in-flight access is dropped: no response is issued. A write whose ACCESS edge has not yet occurred does not happen.
  - Ready stays 0 while `rst` is high.

## Timing

- Cycle numbering is relative to the handshake cycle, cycle 0.
- **Write**
  - `mem_write` is high in cycle 1; the data is stored at the end of cycle 1.
  - The next handshake is possible in cycle 2.
  - Throughput: 1 write per 2 cycles.
- **Read**
  - `mem_read` is high in cycle 1.
  - `mem_rdata` is valid in cycle 2.
  - `rX_rsp_valid` and `rsp_rdata` are valid in cycle 3.
  - Latency is 3; the next handshake is possible in cycle 3.
  - Throughput: 1 read per 3 cycles.
- A read issued right after a write to the same address returns the new data.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Test plan

- **Write then read back.** After reset, r0 writes addr 5 = 8'hA5, then reads addr 5. Required: `mem_write` high for 1 cycle with `mem_addr` = 5; `r0_rsp_valid` pulses exactly 3 cycles after the read handshake with `rsp_rdata` = 8'hA5; `r1_rsp_valid` stays 0.
- **Simultaneous requests.** From reset, r0 reads addr 3 and r1 reads addr 7 in the same cycle (mem[3] = 8'h33, mem[7] = 8'h77 preloaded). Required: r0 is granted first and its response is 8'h33; r1 is then granted at its response cycle and its response is 8'h77, 3 cycles later.
- **Fairness.** Both requesters issue writes continuously, 6 requests each. Required: grant order 0,1,0,1…; one handshake every 2 cycles; all 12 writes land in memory.
- **Boundary addresses.** Writes to addr 0 and 31 with 8'h00 and 8'hFF, then read back. Required: the read-back values are exact; `mem_read` and `mem_write` are never high together (check with an assertion over the whole run).
- **Reset mid-read.** Assert `rst` during RDWAIT. Required: `busy`, `mem_*` and all `rsp_valid` go to 0 immediately; no response pulse ever appears for the dropped read; the first request after reset is served normally.
- **Reset before write access.** Assert `rst` in the handshake cycle of a write of 8'h5A to addr 9. Required: mem[9] is unchanged and `mem_write` never rises.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-port round-robin arbiter / sequencer for a 32x8 sync RAM
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rsp_valid,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_rsp_id;
  logic              w_sel;
  logic              w_hs;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the requester not granted last wins; a lone requester always wins.
  always_comb begin
    w_sel = 1'b0;
    if (r0_valid && r1_valid) w_sel = ~r_last_grant;
    else if (r1_valid)        w_sel = 1'b1;
  end

  assign r0_ready = (r_state == IDLE) && !rst && r0_valid && !w_sel;
  assign r1_ready = (r_state == IDLE) && !rst && r1_valid &&  w_sel;
  assign w_hs     = r0_ready | r1_ready;
  assign w_we     = w_sel ? r1_we    : r0_we;
  assign w_addr   = w_sel ? r1_addr  : r0_addr;
  assign w_wdata  = w_sel ? r1_wdata : r0_wdata;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = mem_read ? RDWAIT : IDLE;
      RDWAIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes and response pulses are single-cycle: cleared unless re-loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rsp_rdata    <= '0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
    end else begin
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      if (w_hs) begin
        mem_read     <= ~w_we;
        mem_write    <= w_we;
        mem_addr     <= w_addr;
        mem_wdata    <= w_wdata;
        r_last_grant <= w_sel;
        r_rsp_id     <= w_sel;
      end
      if (r_state == RDWAIT) begin
        rsp_rdata    <= mem_rdata;
        r0_rsp_valid <= ~r_rsp_id;
        r1_rsp_valid <= r_rsp_id;
      end
    end
  end

endmodule
`default_nettype wire
